// File: rtl/rotate_pkg.sv
// Shared constants for the tile rotation path: rotation codes, tile geometry and
// the fill/drain state encoding used by core_tile_buffer.
package rotate_pkg;

  localparam logic [1:0] DEG_0   = 2'd0;
  localparam logic [1:0] DEG_90  = 2'd1;
  localparam logic [1:0] DEG_180 = 2'd2;
  localparam logic [1:0] DEG_270 = 2'd3;

  localparam int TILE_DIM   = 8;
  localparam int BPP        = 3;
  localparam int TILE_BYTES = TILE_DIM * TILE_DIM * BPP;
  localparam int TILE_BEATS = TILE_BYTES / 4;

  localparam logic [2:0] DIM_MAX   = 3'(TILE_DIM - 1);
  localparam logic [5:0] LAST_BEAT = 6'(TILE_BEATS - 1);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/core_rot_index.sv
// Maps one output byte index of the rotated tile to the byte index it is read from
// in the row-major source tile.
module core_rot_index
  import rotate_pkg::*;
(
  input  logic [1:0] rot,
  input  logic [7:0] out_idx,
  output logic [7:0] src_idx
);

  logic [5:0] pix;
  logic [1:0] ch;
  logic [2:0] r, c, sr, sc;

  // NOTE: every variable gets a value before any branch so no latch can be inferred.
  always_comb begin
    pix = 6'(out_idx / 8'(BPP));
    ch  = 2'(out_idx - {2'b00, pix} * 8'(BPP));
    r   = pix[5:3];
    c   = pix[2:0];
    sr  = r;
    sc  = c;
    case (rot)
      DEG_0:   begin sr = r;           sc = c;           end
      DEG_90:  begin sr = DIM_MAX - c; sc = r;           end
      DEG_180: begin sr = DIM_MAX - r; sc = DIM_MAX - c; end
      DEG_270: begin sr = c;           sc = DIM_MAX - r; end
      default: begin sr = r;           sc = c;           end
    endcase
    src_idx = {2'b00, sr, sc} * 8'(BPP) + {6'b0, ch};
  end

endmodule

// File: rtl/core_tile_buffer.sv
// Single-tile buffer: captures an 8x8 RGB888 tile from the read stream, then replays
// it as write beats reordered for the rotation latched at the end of the fill.
module core_tile_buffer
  import rotate_pkg::*;
(
  input  logic        I_HCLK,
  input  logic        I_HRESET,
  input  logic        I_DIRECTION,
  input  logic [1:0]  I_DEGREES,
  input  logic        I_CLEAR,
  input  logic [31:0] I_RDATA,
  input  logic        I_RVALID,
  output logic        O_RREADY,
  output logic [31:0] O_WDATA,
  output logic        O_WVALID,
  input  logic        I_WREADY,
  output logic        O_TILE_DONE
);

  state_e     state, state_nxt;
  logic [5:0] beat_cnt, cnt_nxt;
  logic [1:0] rot, rot_nxt;
  logic       tile_done, done_nxt;
  logic       fill_we;

  logic [7:0] mem [0:TILE_BYTES-1];
  logic [7:0] src_idx [4];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge I_HCLK or posedge I_HRESET) begin
    if (I_HRESET) begin
      state     <= FILL;
      beat_cnt  <= '0;
      rot       <= DEG_0;
      tile_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      beat_cnt  <= cnt_nxt;
      rot       <= rot_nxt;
      tile_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = beat_cnt;
    rot_nxt   = rot;
    done_nxt  = 1'b0;
    fill_we   = 1'b0;
    if (I_CLEAR) begin
      state_nxt = FILL;
      cnt_nxt   = '0;
    end else if (beat_cnt > LAST_BEAT) begin
      cnt_nxt = '0;
    end else begin
      case (state)
        FILL: begin
          if (I_RVALID) begin
            fill_we = 1'b1;
            if (beat_cnt == LAST_BEAT) begin
              cnt_nxt   = '0;
              state_nxt = DRAIN;
              // Counter-clockwise turns are folded into the equivalent clockwise turn.
              rot_nxt   = I_DIRECTION ? I_DEGREES : 2'd0 - I_DEGREES;
            end else begin
              cnt_nxt = beat_cnt + 6'd1;
            end
          end
        end
        DRAIN: begin
          if (I_WREADY) begin
            if (beat_cnt == LAST_BEAT) begin
              cnt_nxt   = '0;
              state_nxt = FILL;
              done_nxt  = 1'b1;
            end else begin
              cnt_nxt = beat_cnt + 6'd1;
            end
          end
        end
        default: state_nxt = FILL;
      endcase
    end
  end

  // NOTE: tile storage carries no reset; it is always fully rewritten before it is read.
  always_ff @(posedge I_HCLK) begin
    if (fill_we) begin
      for (int k = 0; k < 4; k++) begin
        mem[{beat_cnt, 2'(k)}] <= I_RDATA[8*k +: 8];
      end
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    core_rot_index u_rot_index (
      .rot     (rot),
      .out_idx ({beat_cnt, 2'(k)}),
      .src_idx (src_idx[k])
    );
  end

  always_comb begin
    O_WDATA = '0;
    if (state == DRAIN) begin
      O_WDATA = {mem[src_idx[3]], mem[src_idx[2]], mem[src_idx[1]], mem[src_idx[0]]};
    end
  end

  assign O_RREADY    = (state == FILL);
  assign O_WVALID    = (state == DRAIN);
  assign O_TILE_DONE = tile_done;

endmodule

// File: tb/tb_core_tile_buffer.sv
// Directed bench for core_tile_buffer: fills tiles with a byte-ramp pattern and checks
// the rotated drain against a forward-rotation model of the image.
module tb_core_tile_buffer;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        direction;
  logic [1:0]  degrees;
  logic        clear;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic        tile_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  exp_bytes [192];
  logic [31:0] first;

  core_tile_buffer dut (
    .I_HCLK      (hclk),
    .I_HRESET    (hreset),
    .I_DIRECTION (direction),
    .I_DEGREES   (degrees),
    .I_CLEAR     (clear),
    .I_RDATA     (rdata),
    .I_RVALID    (rvalid),
    .O_RREADY    (rready),
    .O_WDATA     (wdata),
    .O_WVALID    (wvalid),
    .I_WREADY    (wready),
    .O_TILE_DONE (tile_done)
  );

  always #5 hclk = ~hclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Forward model: each source pixel is moved to its destination position in the rotated image.
  task automatic build_expected(input int rot, input logic [7:0] key);
    int r, c;
    for (int sr = 0; sr < 8; sr++) begin
      for (int sc = 0; sc < 8; sc++) begin
        case (rot)
          0:       begin r = sr;     c = sc;     end
          1:       begin r = sc;     c = 7 - sr; end
          2:       begin r = 7 - sr; c = 7 - sc; end
          default: begin r = 7 - sc; c = sr;     end
        endcase
        for (int ch = 0; ch < 3; ch++) begin
          exp_bytes[(r*8 + c)*3 + ch] = 8'((sr*8 + sc)*3 + ch) ^ key;
        end
      end
    end
  endtask

  function automatic logic [31:0] exp_beat(input int k);
    return {exp_bytes[4*k+3], exp_bytes[4*k+2], exp_bytes[4*k+1], exp_bytes[4*k]};
  endfunction

  // Called at a falling edge; returns at the falling edge after the last accepted beat.
  task automatic fill(input logic dir, input logic [1:0] deg, input logic [7:0] key, input int n);
    direction = dir;
    degrees   = deg;
    for (int k = 0; k < n; k++) begin
      rdata  = {8'(4*k+3) ^ key, 8'(4*k+2) ^ key, 8'(4*k+1) ^ key, 8'(4*k) ^ key};
      rvalid = 1'b1;
      @(negedge hclk);
    end
    rvalid = 1'b0;
    rdata  = '0;
  endtask

  task automatic drain(input logic bp, input string tag, output logic [31:0] first_beat);
    int          beats = 0;
    int          cyc   = 0;
    int          dones = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev = '0;
    first_beat = '0;
    while (beats < 48 && cyc < 400) begin
      cyc++;
      if (tile_done) dones++;
      check({tag, "_wvalid"}, 32'(wvalid), 32'd1);
      check({tag, "_wdata"}, wdata, exp_beat(beats));
      if (prev_stall) check({tag, "_stable"}, wdata, prev);
      if (beats == 0) first_beat = wdata;
      wready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bp) begin
        rvalid = 1'($urandom_range(0, 1));
        rdata  = 32'hDEADBEEF;
      end
      if (beats == 1) begin
        direction = ~direction;
        degrees   = degrees + 2'd1;
      end
      prev_stall = !wready;
      prev       = wdata;
      if (wready) beats++;
      @(negedge hclk);
    end
    wready = 1'b0;
    rvalid = 1'b0;
    check({tag, "_beats"}, 32'(beats), 32'd48);
    check({tag, "_early_done"}, 32'(dones), 32'd0);
    check({tag, "_done_pulse"}, 32'(tile_done), 32'd1);
    check({tag, "_wvalid_off"}, 32'(wvalid), 32'd0);
    check({tag, "_rready_back"}, 32'(rready), 32'd1);
    @(negedge hclk);
    check({tag, "_done_single"}, 32'(tile_done), 32'd0);
  endtask

  initial begin
    hreset    = 1'b1;
    direction = 1'b0;
    degrees   = 2'd0;
    clear     = 1'b0;
    rdata     = '0;
    rvalid    = 1'b0;
    wready    = 1'b0;
    repeat (2) @(negedge hclk);
    check("reset_rready", 32'(rready), 32'd1);
    check("reset_wvalid", 32'(wvalid), 32'd0);
    check("reset_done", 32'(tile_done), 32'd0);
    check("reset_wdata", wdata, 32'd0);
    hreset = 1'b0;
    @(negedge hclk);

    // 0 degrees: identity replay
    build_expected(0, 8'h00);
    fill(1'b1, 2'd0, 8'h00, 48);
    check("t1_latency", 32'(wvalid), 32'd1);
    drain(1'b0, "t1", first);
    check("t1_beat0", first, 32'h03020100);

    // 90 degrees clockwise
    build_expected(1, 8'h00);
    fill(1'b1, 2'd1, 8'h00, 48);
    drain(1'b0, "t2", first);
    check("t2_beat0", first, 32'h90AAA9A8);

    // 180 degrees in both directions
    build_expected(2, 8'h00);
    fill(1'b1, 2'd2, 8'h00, 48);
    drain(1'b0, "t3cw", first);
    check("t3cw_beat0", first, 32'hBABFBEBD);
    fill(1'b0, 2'd2, 8'h00, 48);
    drain(1'b0, "t3ccw", first);
    check("t3ccw_beat0", first, 32'hBABFBEBD);

    // 90 counter-clockwise is 270 clockwise
    build_expected(3, 8'h00);
    fill(1'b0, 2'd1, 8'h00, 48);
    drain(1'b0, "t4", first);
    check("t4_beat0", first, 32'h2D171615);

    // Random write backpressure with read beats offered during drain
    fill(1'b1, 2'd3, 8'h00, 48);
    drain(1'b1, "t5", first);
    check("t5_beat0", first, 32'h2D171615);

    // Clear in the middle of a drain
    build_expected(0, 8'h00);
    fill(1'b1, 2'd0, 8'h00, 48);
    for (int i = 0; i < 20; i++) begin
      wready = 1'b1;
      @(negedge hclk);
    end
    check("t6_beat20", wdata, exp_beat(20));
    clear  = 1'b1;
    wready = 1'b1;
    @(negedge hclk);
    clear  = 1'b0;
    wready = 1'b0;
    check("t6_clear_rready", 32'(rready), 32'd1);
    check("t6_clear_wvalid", 32'(wvalid), 32'd0);
    check("t6_clear_wdata", wdata, 32'd0);
    check("t6_clear_done", 32'(tile_done), 32'd0);
    @(negedge hclk);
    check("t6_clear_no_done", 32'(tile_done), 32'd0);

    // Reset in the middle of a fill
    fill(1'b1, 2'd1, 8'h00, 30);
    rdata  = 32'h7B7A7978;
    rvalid = 1'b1;
    #2;
    hreset = 1'b1;
    #1;
    check("t6_rst_rready", 32'(rready), 32'd1);
    check("t6_rst_wvalid", 32'(wvalid), 32'd0);
    check("t6_rst_wdata", wdata, 32'd0);
    check("t6_rst_done", 32'(tile_done), 32'd0);
    @(negedge hclk);
    hreset = 1'b0;
    rvalid = 1'b0;
    @(negedge hclk);

    // Fresh tile after the interrupts, with a different byte pattern
    build_expected(1, 8'hA5);
    fill(1'b0, 2'd3, 8'hA5, 48);
    check("t6_latency", 32'(wvalid), 32'd1);
    drain(1'b0, "t6new", first);
    check("t6new_beat0", first, 32'h350F0C0D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
